// File: rtl/pci_target_device.sv
// PCI memory target claiming word addresses BASE_ADDR..BASE_ADDR+DEPTH-1 with FRAME/IRDY/TRDY/DEVSEL/STOP handshaking.
// Define PCI_TARGET_WAIT_STATE_EN to insert one target wait state in front of every data transfer.
module pci_target_device #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 10
) (
  input  logic            CLK,
  input  logic            RST_N,
  inout  wire logic [31:0] AD,
  input  logic [3:0]      CBE_N,
  input  logic            FRAME_N,
  input  logic            IRDY_N,
  output wire logic       TRDY_N,
  output wire logic       DEVSEL_N,
  output wire logic       STOP_N
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]    CMD_MEM_RD = 4'b0110;
  localparam logic [3:0]    CMD_MEM_WR = 4'b0111;
  localparam logic [IW-1:0] LAST_IDX   = IW'(DEPTH - 1);
`ifdef PCI_TARGET_WAIT_STATE_EN
  localparam logic WAIT_EN = 1'b1;
`else
  localparam logic WAIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WRITE, TURN, READ, DISC, BACKOFF} state_t;

  state_t        state_reg, state_next;
  logic          frame_reg;
  logic [IW-1:0] idx_reg, idx_next;
  logic          wait_reg, wait_next;
  logic [31:0]   offset;
  logic [31:0]   rd_data;
  logic          hit, addr_phase, wr_en;
  logic          drive_ctl, drive_ad, devsel, trdy, stop;

  assign offset     = AD - BASE_ADDR;
  assign hit        = offset < 32'(DEPTH);
  assign addr_phase = !FRAME_N && frame_reg;
  assign wr_en      = (state_reg == WRITE) && !IRDY_N && !wait_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      frame_reg <= 1'b1;
      idx_reg   <= '0;
      wait_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      frame_reg <= FRAME_N;
      idx_reg   <= idx_next;
      wait_reg  <= wait_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    wait_next  = wait_reg;
    drive_ctl  = 1'b1;
    drive_ad   = 1'b0;
    devsel     = 1'b0;
    trdy       = 1'b1;
    stop       = 1'b1;
    unique case (state_reg)
      IDLE: begin
        drive_ctl = 1'b0;
        if (addr_phase && hit && (CBE_N == CMD_MEM_WR || CBE_N == CMD_MEM_RD)) begin
          state_next = (CBE_N == CMD_MEM_WR) ? WRITE : TURN;
          idx_next   = offset[IW-1:0];
          wait_next  = WAIT_EN;
        end
      end
      TURN: state_next = READ;
      WRITE, READ: begin
        trdy      = wait_reg;
        // Disconnect-with-data: STOP accompanies the final word only while the master still wants more.
        stop      = !((idx_reg == LAST_IDX) && !FRAME_N);
        drive_ad  = (state_reg == READ);
        wait_next = 1'b0;
        if (!IRDY_N && !wait_reg) begin
          wait_next = WAIT_EN;
          if (FRAME_N)
            state_next = BACKOFF;
          else if (idx_reg == LAST_IDX)
            state_next = DISC;
          else
            idx_next = idx_reg + IW'(1);
        end else if (FRAME_N && IRDY_N) begin
          state_next = BACKOFF;
        end
      end
      DISC: begin
        stop = 1'b0;
        if (FRAME_N)
          state_next = BACKOFF;
      end
      BACKOFF: begin
        devsel     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        drive_ctl  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // One storage array per byte lane so each byte enable writes its own lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_reg [DEPTH];
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        for (int w = 0; w < DEPTH; w++)
          lane_reg[w] <= 8'h00;
      end else if (wr_en && !CBE_N[gi]) begin
        lane_reg[idx_reg] <= AD[8*gi +: 8];
      end
    end
    assign rd_data[8*gi +: 8] = lane_reg[idx_reg];
  end

  assign DEVSEL_N = drive_ctl ? devsel : 1'bz;
  assign TRDY_N   = drive_ctl ? trdy   : 1'bz;
  assign STOP_N   = drive_ctl ? stop   : 1'bz;
  assign AD       = drive_ad  ? rd_data : 32'bz;
endmodule

// File: tb/tb_pci_target_device.sv
// Bench for pci_target_device: acts as PCI master, predicts every bus cycle from a transaction-level model.
module tb_pci_target_device;
  localparam logic [31:0] BASE  = 32'h0000_000A;
  localparam int          DEPTH = 10;
`ifdef PCI_TARGET_WAIT_STATE_EN
  localparam int WS = 1;
`else
  localparam int WS = 0;
`endif
  localparam logic [3:0] RD = 4'b0110;
  localparam logic [3:0] WR = 4'b0111;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  wire  [31:0] AD;
  logic [3:0]  CBE_N = 4'hF;
  logic        FRAME_N = 1'b1;
  logic        IRDY_N = 1'b1;
  wire         TRDY_N, DEVSEL_N, STOP_N;
  logic        ad_oe = 1'b0;
  logic [31:0] ad_drv = 32'h0;

  assign AD = ad_oe ? ad_drv : 32'bz;
  pullup (TRDY_N);
  pullup (DEVSEL_N);
  pullup (STOP_N);

  pci_target_device #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .AD(AD), .CBE_N(CBE_N), .FRAME_N(FRAME_N),
    .IRDY_N(IRDY_N), .TRDY_N(TRDY_N), .DEVSEL_N(DEVSEL_N), .STOP_N(STOP_N)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_xfer;
  logic        exp_on = 1'b1;
  logic        exp_devsel = 1'b1, exp_trdy = 1'b1, exp_stop = 1'b1, exp_ad_chk = 1'b0;
  logic [31:0] exp_ad = 32'h0;
  logic [31:0] ad_cap;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] rd_q[$];
  logic [31:0] wdata_q[$];
  logic [3:0]  wbe_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_on) begin
      check("devsel_n", 32'(DEVSEL_N), 32'(exp_devsel));
      check("trdy_n", 32'(TRDY_N), 32'(exp_trdy));
      check("stop_n", 32'(STOP_N), 32'(exp_stop));
      if (exp_ad_chk) check("ad_read", AD, exp_ad);
    end
  end

  // One bus cycle: drive master signals, publish the expected target response, capture AD.
  task automatic cycle(input logic f, input logic i, input logic [3:0] c, input logic oe,
                       input logic [31:0] d, input logic ed, input logic et, input logic es,
                       input logic ea, input logic [31:0] ead);
    @(posedge CLK); #1;
    FRAME_N = f; IRDY_N = i; CBE_N = c; ad_oe = oe; ad_drv = d;
    exp_devsel = ed; exp_trdy = et; exp_stop = es; exp_ad_chk = ea; exp_ad = ead;
    @(negedge CLK); #1;
    ad_cap = AD;
  endtask

  task automatic txn(input logic [3:0] cmd, input logic [31:0] addr, input int len, input int abort_at);
    logic [31:0] off, d;
    logic [3:0]  be;
    logic        f, i, et, es, is_wr, is_rd, done, disc;
    int          idx, w, mwait, ws_left, hold;
    off   = addr - BASE;
    is_wr = (cmd == WR);
    is_rd = (cmd == RD);
    rd_q.delete();
    n_xfer = 0;
    cycle(L, H, cmd, H, addr, H, H, H, L, 32'h0);
    if (off >= 32'(DEPTH) || !(is_wr || is_rd)) begin
      for (int k = 0; k < len; k++) cycle(k == len - 1, L, 4'h0, H, $urandom, H, H, H, L, 32'h0);
      cycle(H, H, 4'hF, L, 32'h0, H, H, H, L, 32'h0);
      wdata_q.delete(); wbe_q.delete();
      return;
    end
    idx = int'(off);
    if (is_rd) cycle(L, H, 4'h0, L, 32'h0, L, H, H, L, 32'h0);
    w = 0; ws_left = WS; mwait = $urandom_range(0, 2); done = 1'b0; disc = 1'b0;
    while (!done) begin
      if (w == abort_at) begin f = H; i = H; end
      else if (mwait > 0) begin f = L; i = H; end
      else begin f = (w == len - 1); i = L; end
      be = (wbe_q.size() > 0) ? wbe_q[0] : 4'($urandom);
      d  = (wdata_q.size() > 0) ? wdata_q[0] : $urandom;
      et = (ws_left > 0);
      es = !((idx == DEPTH - 1) && !f);
      cycle(f, i, is_wr ? be : 4'h0, is_wr, d, L, et, es, is_rd, mem_m[idx]);
      if (f && i) begin
        done = 1'b1;
      end else if (!i && !et) begin
        if (is_wr) begin
          for (int b = 0; b < 4; b++) if (!be[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
          if (wdata_q.size() > 0) void'(wdata_q.pop_front());
          if (wbe_q.size() > 0) void'(wbe_q.pop_front());
        end else begin
          rd_q.push_back(ad_cap);
        end
        n_xfer++; w++;
        if (f) done = 1'b1;
        else if (idx == DEPTH - 1) begin done = 1'b1; disc = 1'b1; end
        else begin idx++; ws_left = WS; mwait = $urandom_range(0, 2); end
      end else begin
        if (ws_left > 0) ws_left--;
        if (mwait > 0) mwait--;
      end
    end
    if (disc) begin
      hold = $urandom_range(1, 3);
      for (int k = 0; k < hold; k++) cycle(L, L, 4'h0, is_wr, $urandom, L, H, L, L, 32'h0);
      cycle(H, L, 4'h0, is_wr, 32'h0, L, H, L, L, 32'h0);
    end
    cycle(H, H, 4'hF, L, 32'h0, H, H, H, L, 32'h0);
    cycle(H, H, 4'hF, L, 32'h0, H, H, H, L, 32'h0);
    wdata_q.delete(); wbe_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) mem_m[k] = 32'h0;
    repeat (3) @(negedge CLK);
    check("rst_devsel_z", 32'(DEVSEL_N), 32'h1);
    check("rst_trdy_z", 32'(TRDY_N), 32'h1);
    RST_N = 1'b1;

    wdata_q = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    wbe_q   = '{4'h0, 4'h0, 4'h0};
    txn(WR, 32'h0A, 3, -1);
    check("burst_wr_xfers", 32'(n_xfer), 32'd3);

    txn(RD, 32'h0B, 2, -1);
    check("rd_0b_word0", rd_q[0], 32'h2222_2222);
    check("rd_0b_word1", rd_q[1], 32'h3333_3333);

    txn(WR, 32'h05, 2, -1);
    txn(4'b0010, 32'h0A, 2, -1);
    txn(RD, 32'h0A, 3, -1);
    check("miss_keep0", rd_q[0], 32'h1111_1111);
    check("miss_keep1", rd_q[1], 32'h2222_2222);
    check("miss_keep2", rd_q[2], 32'h3333_3333);

    wdata_q = '{32'hAABB_CCDD};
    wbe_q   = '{4'b1100};
    txn(WR, 32'h0C, 1, -1);
    check("be_model", mem_m[2], 32'h3333_CCDD);
    txn(RD, 32'h0C, 1, -1);
    check("be_readback", rd_q[0], 32'h3333_CCDD);

    wdata_q = '{32'h8888_0008, 32'h9999_0009, 32'hDEAD_0000, 32'hDEAD_0001};
    wbe_q   = '{4'h0, 4'h0, 4'h0, 4'h0};
    txn(WR, 32'h12, 4, -1);
    check("disc_xfers", 32'(n_xfer), 32'd2);
    txn(RD, 32'h12, 2, -1);
    check("disc_word8", rd_q[0], 32'h8888_0008);
    check("disc_word9", rd_q[1], 32'h9999_0009);
    txn(RD, 32'h0A, 1, -1);
    check("no_wrap", rd_q[0], 32'h1111_1111);

    for (int t = 0; t < 150; t++) begin
      automatic int r = $urandom_range(0, 9);
      automatic logic [3:0] cmd = (r < 4) ? WR : (r < 8) ? RD : 4'($urandom);
      automatic logic [31:0] addr = BASE - 32'd3 + 32'($urandom_range(0, DEPTH + 5));
      automatic int len = $urandom_range(1, 5);
      automatic int ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      txn(cmd, addr, len, ab);
    end

    // Asynchronous reset in the middle of a read burst, between clock edges.
    cycle(L, H, RD, H, 32'h0A, H, H, H, L, 32'h0);
    cycle(L, H, 4'h0, L, 32'h0, L, H, H, L, 32'h0);
    cycle(L, H, 4'h0, L, 32'h0, L, (WS > 0), H, H, mem_m[0]);
    #2;
    exp_devsel = H; exp_trdy = H; exp_stop = H; exp_ad_chk = L;
    RST_N = 1'b0;
    #1;
    check("arst_devsel_z", 32'(DEVSEL_N), 32'h1);
    check("arst_trdy_z", 32'(TRDY_N), 32'h1);
    check("arst_stop_z", 32'(STOP_N), 32'h1);
    for (int k = 0; k < DEPTH; k++) mem_m[k] = 32'h0;
    FRAME_N = 1'b1; IRDY_N = 1'b1; ad_oe = 1'b0;
    @(posedge CLK); @(posedge CLK); #3;
    RST_N = 1'b1;

    txn(RD, 32'h0A, 3, -1);
    check("arst_clear0", rd_q[0], 32'h0);
    check("arst_clear1", rd_q[1], 32'h0);
    check("arst_clear2", rd_q[2], 32'h0);
    wdata_q = '{32'hCAFE_F00D};
    wbe_q   = '{4'h0};
    txn(WR, 32'h10, 1, -1);
    txn(RD, 32'h10, 1, -1);
    check("post_rst_rw", rd_q[0], 32'hCAFE_F00D);

    exp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
